// File: rtl/row_page_scheduler_if.sv
// row_page_scheduler_if
// Groups the scheduler's bus signals.
//   byteReady/byteData : UART receive strobe and byte
//   charAddress        : text engine char index, [5:4] row, [3:0] column
//   srcChars           : packed source characters, source s at [8s+7:8s]
//   charOutput         : selected character (registered)
//   activeSrc          : source index of the last lookup
//   page/rotateEn      : current page and auto-rotation state
// master = the side driving inputs (text engine / UART), slave = the scheduler.
interface row_page_scheduler_if #(
  parameter int NUM_SRC = 4
);
  logic                   byteReady;
  logic [7:0]             byteData;
  logic [5:0]             charAddress;
  logic [8*NUM_SRC-1:0]   srcChars;
  logic [7:0]             charOutput;
  logic [1:0]             activeSrc;
  logic [1:0]             page;
  logic                   rotateEn;

  modport master (
    output byteReady, byteData, charAddress, srcChars,
    input  charOutput, activeSrc, page, rotateEn
  );

  modport slave (
    input  byteReady, byteData, charAddress, srcChars,
    output charOutput, activeSrc, page, rotateEn
  );
endinterface

// File: rtl/row_page_scheduler.sv
// row_page_scheduler
// Selects which character source drives each of the four OLED text rows.
// A page table maps (page,row) to a source; pages auto-rotate on a timer and
// UART commands remap rows ('R' row src), select a page ('P' n) or toggle
// rotation ('H').
// Ports:
//   clk   : system clock
//   rstN  : asynchronous active-low reset
//   bus   : row_page_scheduler_if.slave (UART bytes, char lookup, status)
// Optional build macro PAGE_INDICATOR_EN: row 0 column 15 shows '0'+page.
module row_page_scheduler #(
  parameter int NUM_SRC       = 4,
  parameter int NUM_PAGES     = 2,
  parameter int ROTATE_TICKS  = 27000000,
  parameter int PARSE_TIMEOUT = 2700000
) (
  input  logic                  clk,
  input  logic                  rstN,
  row_page_scheduler_if.slave   bus
);

  localparam int ROT_W = ($clog2(ROTATE_TICKS) > 0) ? $clog2(ROTATE_TICKS) : 1;
  localparam int TO_W  = ($clog2(PARSE_TIMEOUT) > 0) ? $clog2(PARSE_TIMEOUT) : 1;
  localparam logic [ROT_W-1:0] ROT_LAST = ROT_W'(ROTATE_TICKS - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(PARSE_TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_GET_ROW  = 2'd1;
  localparam logic [1:0] ST_GET_SRC  = 2'd2;
  localparam logic [1:0] ST_GET_PAGE = 2'd3;

  // Table is flattened to {page,row} so a 2-bit page always indexes in range.
  logic [1:0]        table_q [16];
  logic [1:0]        state_q, state_d;
  logic [1:0]        row_q, row_d;
  logic [1:0]        page_q, page_d;
  logic              rot_en_q, rot_en_d;
  logic [ROT_W-1:0]  rot_cnt_q, rot_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [7:0]        char_q;
  logic [1:0]        src_q;

  logic              wr_en_s;
  logic [1:0]        wr_src_s;
  logic              page_cmd_s;
  logic [1:0]        digit_s;
  logic              is_row_s, is_src_s, is_page_s;
  logic [1:0]        lk_src_s;
  logic [7:0]        lk_char_s;

  assign digit_s   = 2'(bus.byteData - 8'h30);
  assign is_row_s  = (bus.byteData >= 8'h30) && (bus.byteData <= 8'h33);
  assign is_src_s  = (bus.byteData >= 8'h30) && (bus.byteData <= 8'(8'h2F + NUM_SRC));
  assign is_page_s = (bus.byteData >= 8'h30) && (bus.byteData <= 8'(8'h2F + NUM_PAGES));

  // Command parser and inactivity timeout.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    rot_en_d   = rot_en_q;
    to_cnt_d   = to_cnt_q;
    wr_en_s    = 1'b0;
    wr_src_s   = 2'd0;
    page_cmd_s = 1'b0;
    if (bus.byteReady) begin
      to_cnt_d = '0;
      case (state_q)
        ST_IDLE: begin
          case (bus.byteData)
            8'h52:   state_d = ST_GET_ROW;
            8'h50:   state_d = ST_GET_PAGE;
            8'h48:   rot_en_d = ~rot_en_q;
            default: state_d = ST_IDLE;
          endcase
        end
        ST_GET_ROW: begin
          if (is_row_s) begin
            row_d   = digit_s;
            state_d = ST_GET_SRC;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_GET_SRC: begin
          if (is_src_s) begin
            wr_en_s  = 1'b1;
            wr_src_s = digit_s;
          end else begin
            wr_en_s  = 1'b0;
          end
          state_d = ST_IDLE;
        end
        ST_GET_PAGE: begin
          if (is_page_s) begin
            page_cmd_s = 1'b1;
          end else begin
            page_cmd_s = 1'b0;
          end
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      if (to_cnt_q == TO_LAST) begin
        state_d  = ST_IDLE;
        to_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end else begin
      to_cnt_d = '0;
    end
  end

  // Page rotation; a 'P' commit overrides a coincident timer wrap.
  always_comb begin
    page_d    = page_q;
    rot_cnt_d = rot_cnt_q;
    if (page_cmd_s) begin
      page_d    = digit_s;
      rot_cnt_d = '0;
    end else if (rot_en_q) begin
      if (rot_cnt_q == ROT_LAST) begin
        rot_cnt_d = '0;
        page_d    = (page_q == 2'(NUM_PAGES - 1)) ? 2'd0 : page_q + 2'd1;
      end else begin
        rot_cnt_d = rot_cnt_q + 1'b1;
      end
    end else begin
      rot_cnt_d = rot_cnt_q;
    end
  end

  // Character lookup from the pre-edge page and table.
  always_comb begin
    lk_src_s  = table_q[{page_q, bus.charAddress[5:4]}];
    lk_char_s = 8'h20;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (lk_src_s == 2'(s)) begin
        lk_char_s = bus.srcChars[8*s +: 8];
      end else begin
        lk_char_s = lk_char_s;
      end
    end
`ifdef PAGE_INDICATOR_EN
    if (bus.charAddress == 6'h0F) begin
      lk_char_s = 8'h30 + {6'd0, page_q};
    end else begin
      lk_char_s = lk_char_s;
    end
`endif
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q   <= ST_IDLE;
      row_q     <= 2'd0;
      page_q    <= 2'd0;
      rot_en_q  <= 1'b1;
      rot_cnt_q <= '0;
      to_cnt_q  <= '0;
      char_q    <= 8'h20;
      src_q     <= 2'd0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      page_q    <= page_d;
      rot_en_q  <= rot_en_d;
      rot_cnt_q <= rot_cnt_d;
      to_cnt_q  <= to_cnt_d;
      char_q    <= lk_char_s;
      src_q     <= lk_src_s;
    end
  end

  // Page table; the write lands on the page current in the commit cycle.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < 16; i++) begin
        table_q[i] <= 2'(((i % 4) + (i / 4)) % NUM_SRC);
      end
    end else if (wr_en_s) begin
      table_q[{page_q, row_q}] <= wr_src_s;
    end else begin
      table_q <= table_q;
    end
  end

  assign bus.charOutput = char_q;
  assign bus.activeSrc  = src_q;
  assign bus.page       = page_q;
  assign bus.rotateEn   = rot_en_q;

endmodule

// File: doc/row_page_scheduler.md
Name: row_page_scheduler

Overview:
- Decides which content source drives each of the four OLED text rows.
- Sits between the text engine's character fetch (charAddress/charOutput) and the per-row content generators: UART text row, binary row, hex/dec row, progress row.
- Holds a page table of row-to-source mappings, auto-rotates pages on a timer, and accepts UART command bytes to remap rows, select a page or hold rotation.

Parameters:
- NUM_SRC, 4: number of character sources on srcChars; 2..4.
- NUM_PAGES, 2: number of pages in the page table; 1..4.
- ROTATE_TICKS, 27000000: clk cycles per auto-rotation step, i.e. 1 s at 27 MHz.
- PARSE_TIMEOUT, 2700000: idle clk cycles after which a partially received command is discarded.

Ports:
- clk, input, 1: system clock.
- rstN, input, 1: asynchronous active-low reset.
- byteReady, input, 1: one-cycle pulse from the UART receiver; byteData is valid in that cycle.
- byteData, input, 8: received UART byte.
- charAddress, input, 6: text engine char index; [5:4] = row, [3:0] = column.
- srcChars, input, 8*NUM_SRC: packed source characters; source s occupies [8s+7:8s].
- charOutput, output, 8: selected character.
- activeSrc, output, 2: source index selected for the row of the last lookup; the top level uses it to pick pixel-mode rows.
- page, output, 2: current page index.
- rotateEn, output, 1: auto-rotation enabled.

Behaviour:
- Reset (async, rstN=0):
  - charOutput=0x20, activeSrc=0, page=0, rotateEn=1, parser IDLE, rotation counter 0, timeout counter 0.
  - Table entry [p][r] = (r+p) mod NUM_SRC.
- Lookup, latency 1 cycle:
  - r = charAddress[5:4], src = table[page][r].
  - On each clk, charOutput <= srcChars[8*src +: 8] and activeSrc <= src.
  - Lookup uses page and table values as of the start of the cycle.
- Rotation:
  - When rotateEn=1, the counter increments each clk.
  - At ROTATE_TICKS-1 the counter clears and page <= (page+1) mod NUM_PAGES; NUM_PAGES=1 keeps page 0.
  - When rotateEn=0, the counter holds its value.
- Command parser FSM, advancing only on byteReady:
  - IDLE:
    - 'R' (0x52) -> GET_ROW.
    - 'P' (0x50) -> GET_PAGE.
    - 'H' (0x48) toggles rotateEn and stays in IDLE.
    - Any other byte is ignored.
  - GET_ROW: byte '0'..'3' latches the row -> GET_SRC; anything else -> IDLE.
  - GET_SRC: byte '0'..'0'+NUM_SRC-1 writes table[page][row] <= value, then -> IDLE; anything else -> IDLE, no write.
  - GET_PAGE: byte '0'..'0'+NUM_PAGES-1 sets page <= value and clears the rotation counter, then -> IDLE; anything else -> IDLE.
  - The table write targets the page current in the commit cycle.
- Timeout:
  - In any non-IDLE state, the timeout counter increments each cycle without byteReady and clears on byteReady.
  - Reaching PARSE_TIMEOUT-1 forces IDLE with no table or page change.
- Simultaneous events:
  - A 'P' commit in the same cycle as a rotation wrap: the command wins; page = commanded value, counter = 0.
  - 'H' clearing rotateEn in a wrap cycle: the wrap still applies in that cycle.
  - A table write in a cycle whose lookup hits that entry: the lookup returns the old source; the new one appears from the next cycle.
- Reset mid-command: parser returns to IDLE; any partial command is lost.

Optional Feature:
- PAGE_INDICATOR_EN defined:
  - When charAddress = 6'h0F (row 0, column 15), charOutput <= '0'+page; activeSrc still reflects the table.
  - Latency stays 1 cycle.
- Not defined: no override; column 15 of row 0 comes from its mapped source.

Test Plan:
- Reset, srcChars = {"D","C","B","A"} (src0='A'), sweep rows 0..3 -> charOutput one cycle later = 'A','B','C','D'; page=0.
- Run ROTATE_TICKS=8 for 8 cycles -> page=1; row 0 -> 'B', row 3 -> 'A'; after 16 cycles page=0.
- Send 'H','R','2','0' -> rotateEn=0; row 2 returns 'A'; page stays constant across 100 cycles.
- Send 'R','7' -> parser IDLE, table unchanged. Send 'R','1' then wait PARSE_TIMEOUT cycles, then '3' -> no write; row 1 still 'B'.
- Send 'P','1' on the exact cycle the counter wraps -> page=1, counter=0; next wrap occurs ROTATE_TICKS cycles later.
- With PAGE_INDICATOR_EN, page=1, charAddress=6'h0F -> charOutput=0x31; charAddress=6'h0E -> mapped source char.
